// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM states, transaction owner, request vector indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_WAIT_RSP
    } arb_state_e;

    typedef enum logic [1:0] {
        OWNER_NONE,
        OWNER_IF,
        OWNER_LSU
    } arb_owner_e;

    // Bit positions inside the request vector handed to the selector
    localparam int REQ_IF  = 0;
    localparam int REQ_LSU = 1;

endpackage

// File: rtl/mem_port_arbiter_select.sv
// Picks the next memory port owner: LSU by default, IF once it has lost STARVE_LIMIT times in a row.
// Latency: winner is combinational from req and the starve counter; the counter updates on arb_en cycles.
// Backpressure: none; the counter only moves while the arbiter is idle (arb_en high).
module mem_arb_select
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       arb_en,
    input  logic [1:0] req,
    output arb_owner_e winner
);

    localparam int            CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;
    logic          if_forced;

    // Priority pick: LSU wins unless IF has been starved long enough
    always_comb begin
        if_forced = req[REQ_IF] && (starve_cnt == LIMIT);
        winner    = OWNER_NONE;
        if (req[REQ_LSU] && !if_forced) begin
            winner = OWNER_LSU;
        end else if (req[REQ_IF]) begin
            winner = OWNER_IF;
        end
    end

    // Count consecutive LSU wins over a waiting IF; clear when IF is idle or finally wins
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (arb_en) begin
            if (!req[REQ_IF] || winner == OWNER_IF) begin
                starve_cnt <= '0;
            end else if (winner == OWNER_LSU && starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between fetch and LSU, one outstanding transaction at a time.
// Latency: 3 cycles minimum per transaction (arbitrate, request with immediate gnt, response).
// Backpressure: requesters hold req until their gnt; new requests wait until the arbiter returns to idle.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    if_req_ip,
    input  logic [ADDR_WIDTH-1:0]   if_addr_ip,
    output logic                    if_gnt_op,
    output logic                    if_rvalid_op,
    output logic [DATA_WIDTH-1:0]   if_rdata_op,
    input  logic                    lsu_req_ip,
    input  logic                    lsu_we_ip,
    input  logic [DATA_WIDTH/8-1:0] lsu_be_ip,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr_ip,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata_ip,
    output logic                    lsu_gnt_op,
    output logic                    lsu_rvalid_op,
    output logic [DATA_WIDTH-1:0]   lsu_rdata_op,
    output logic                    mem_req_op,
    output logic                    mem_we_op,
    output logic [DATA_WIDTH/8-1:0] mem_be_op,
    output logic [ADDR_WIDTH-1:0]   mem_addr_op,
    output logic [DATA_WIDTH-1:0]   mem_wdata_op,
    input  logic                    mem_gnt_ip,
    input  logic                    mem_rvalid_ip,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_ip,
    output logic                    busy_op
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    arb_state_e            state;
    arb_state_e            state_next;
    arb_owner_e            owner;
    arb_owner_e            winner;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [BE_WIDTH-1:0]   be_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  launch;
    logic                  granted;
    logic                  responded;

    // gnt and rvalid only count in the state that expects them; strays elsewhere are dropped
    assign launch    = (state == ARB_IDLE) && (winner != OWNER_NONE);
    assign granted   = (state == ARB_REQ) && mem_gnt_ip;
    assign responded = (state == ARB_WAIT_RSP) && mem_rvalid_ip;

    mem_arb_select #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_select (
        .clock  (clock),
        .reset  (reset),
        .arb_en (state == ARB_IDLE),
        .req    ({lsu_req_ip, if_req_ip}),
        .winner (winner)
    );

    // State and owner registers; reset abandons any in-flight transaction
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ARB_IDLE;
            owner <= OWNER_NONE;
        end else begin
            state <= state_next;
            if (launch) begin
                owner <= winner;
            end else if (responded) begin
                owner <= OWNER_NONE;
            end
        end
    end

    // Next-state: arbitrate in idle, wait for gnt, then wait for the response
    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE:     if (launch)    state_next = ARB_REQ;
            ARB_REQ:      if (granted)   state_next = ARB_WAIT_RSP;
            ARB_WAIT_RSP: if (responded) state_next = ARB_IDLE;
            default:                     state_next = ARB_IDLE;
        endcase
    end

    // Capture the winner's request fields; fetches are full-word reads
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
        end else if (launch) begin
            if (winner == OWNER_LSU) begin
                addr_q  <= lsu_addr_ip;
                we_q    <= lsu_we_ip;
                be_q    <= lsu_be_ip;
                wdata_q <= lsu_wdata_ip;
            end else begin
                addr_q  <= if_addr_ip;
                we_q    <= 1'b0;
                be_q    <= '1;
                wdata_q <= '0;
            end
        end
    end

    // Drive the memory port and route gnt/response to the owner only; everything reads 0 during reset
    always_comb begin
        mem_req_op    = 1'b0;
        mem_we_op     = 1'b0;
        mem_be_op     = '0;
        mem_addr_op   = '0;
        mem_wdata_op  = '0;
        busy_op       = 1'b0;
        if_gnt_op     = 1'b0;
        lsu_gnt_op    = 1'b0;
        if_rvalid_op  = 1'b0;
        if_rdata_op   = '0;
        lsu_rvalid_op = 1'b0;
        lsu_rdata_op  = '0;
        if (!reset) begin
            mem_req_op   = (state == ARB_REQ);
            mem_we_op    = we_q;
            mem_be_op    = be_q;
            mem_addr_op  = addr_q;
            mem_wdata_op = wdata_q;
            busy_op      = (state != ARB_IDLE);
            if_gnt_op    = granted && (owner == OWNER_IF);
            lsu_gnt_op   = granted && (owner == OWNER_LSU);
            if (responded && owner == OWNER_IF) begin
                if_rvalid_op = 1'b1;
                if_rdata_op  = mem_rdata_ip;
            end
            if (responded && owner == OWNER_LSU) begin
                lsu_rvalid_op = 1'b1;
                lsu_rdata_op  = we_q ? '0 : mem_rdata_ip;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with assertion-based checks.
// Latency: inputs driven 1ns after posedge, outputs sampled 2ns after posedge.
// Backpressure: the bench plays the memory model, driving gnt/rvalid by hand.
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset;
    logic        if_req_ip;
    logic [31:0] if_addr_ip;
    logic        if_gnt_op;
    logic        if_rvalid_op;
    logic [31:0] if_rdata_op;
    logic        lsu_req_ip;
    logic        lsu_we_ip;
    logic [3:0]  lsu_be_ip;
    logic [31:0] lsu_addr_ip;
    logic [31:0] lsu_wdata_ip;
    logic        lsu_gnt_op;
    logic        lsu_rvalid_op;
    logic [31:0] lsu_rdata_op;
    logic        mem_req_op;
    logic        mem_we_op;
    logic [3:0]  mem_be_op;
    logic [31:0] mem_addr_op;
    logic [31:0] mem_wdata_op;
    logic        mem_gnt_ip;
    logic        mem_rvalid_ip;
    logic [31:0] mem_rdata_ip;
    logic        busy_op;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .if_req_ip     (if_req_ip),
        .if_addr_ip    (if_addr_ip),
        .if_gnt_op     (if_gnt_op),
        .if_rvalid_op  (if_rvalid_op),
        .if_rdata_op   (if_rdata_op),
        .lsu_req_ip    (lsu_req_ip),
        .lsu_we_ip     (lsu_we_ip),
        .lsu_be_ip     (lsu_be_ip),
        .lsu_addr_ip   (lsu_addr_ip),
        .lsu_wdata_ip  (lsu_wdata_ip),
        .lsu_gnt_op    (lsu_gnt_op),
        .lsu_rvalid_op (lsu_rvalid_op),
        .lsu_rdata_op  (lsu_rdata_op),
        .mem_req_op    (mem_req_op),
        .mem_we_op     (mem_we_op),
        .mem_be_op     (mem_be_op),
        .mem_addr_op   (mem_addr_op),
        .mem_wdata_op  (mem_wdata_op),
        .mem_gnt_ip    (mem_gnt_ip),
        .mem_rvalid_ip (mem_rvalid_ip),
        .mem_rdata_ip  (mem_rdata_ip),
        .busy_op       (busy_op)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Move to 1ns after the next rising edge, where inputs are changed
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Starts in an idle cycle (at the sample point) with requests already driven.
    // Walks REQ with immediate gnt, then WAIT_RSP with rvalid, and ends at the next idle sample point.
    task automatic run_txn(input string tag, input logic exp_lsu, input logic [31:0] exp_addr,
                           input logic exp_we, input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                           input logic [31:0] rsp, input logic drop_lsu, input logic drop_if);
        tick();
        #1;
        chk({tag, " req"},   {31'd0, mem_req_op}, 32'd1);
        chk({tag, " addr"},  mem_addr_op, exp_addr);
        chk({tag, " we"},    {31'd0, mem_we_op}, {31'd0, exp_we});
        chk({tag, " be"},    {28'd0, mem_be_op}, {28'd0, exp_be});
        chk({tag, " wdata"}, mem_wdata_op, exp_wdata);
        mem_gnt_ip = 1'b1;
        #1;
        chk({tag, " lsu_gnt"}, {31'd0, lsu_gnt_op}, {31'd0, exp_lsu});
        chk({tag, " if_gnt"},  {31'd0, if_gnt_op},  {31'd0, !exp_lsu});
        tick();
        mem_gnt_ip = 1'b0;
        if (drop_lsu) lsu_req_ip = 1'b0;
        if (drop_if)  if_req_ip  = 1'b0;
        #1;
        chk({tag, " req dropped"}, {31'd0, mem_req_op}, 32'd0);
        chk({tag, " gnt once"}, {30'd0, lsu_gnt_op, if_gnt_op}, 32'd0);
        mem_rvalid_ip = 1'b1;
        mem_rdata_ip  = rsp;
        #1;
        chk({tag, " lsu_rvalid"}, {31'd0, lsu_rvalid_op}, {31'd0, exp_lsu});
        chk({tag, " if_rvalid"},  {31'd0, if_rvalid_op},  {31'd0, !exp_lsu});
        chk({tag, " lsu_rdata"}, lsu_rdata_op, (exp_lsu && !exp_we) ? rsp : 32'd0);
        chk({tag, " if_rdata"},  if_rdata_op,  exp_lsu ? 32'd0 : rsp);
        tick();
        mem_rvalid_ip = 1'b0;
        mem_rdata_ip  = 32'd0;
        #1;
        chk({tag, " idle busy"}, {31'd0, busy_op}, 32'd0);
        chk({tag, " idle rvalid"}, {30'd0, lsu_rvalid_op, if_rvalid_op}, 32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        if_req_ip     = 1'b0;
        if_addr_ip    = 32'd0;
        lsu_req_ip    = 1'b0;
        lsu_we_ip     = 1'b0;
        lsu_be_ip     = 4'h0;
        lsu_addr_ip   = 32'd0;
        lsu_wdata_ip  = 32'd0;
        mem_gnt_ip    = 1'b0;
        mem_rvalid_ip = 1'b0;
        mem_rdata_ip  = 32'd0;

        // Reset: outputs low while asserted and in the first cycle after
        tick();
        tick();
        #1;
        chk("rst busy", {31'd0, busy_op}, 32'd0);
        chk("rst mem_req", {31'd0, mem_req_op}, 32'd0);
        chk("rst addr", mem_addr_op, 32'd0);
        reset = 1'b0;
        tick();
        #1;
        chk("post-rst busy", {31'd0, busy_op}, 32'd0);
        chk("post-rst outputs", {27'd0, mem_req_op, if_gnt_op, lsu_gnt_op, if_rvalid_op, lsu_rvalid_op}, 32'd0);

        // LSU load alone
        lsu_req_ip  = 1'b1;
        lsu_addr_ip = 32'h100;
        lsu_we_ip   = 1'b0;
        lsu_be_ip   = 4'hF;
        #1;
        chk("load idle busy", {31'd0, busy_op}, 32'd0);
        run_txn("load", 1'b1, 32'h100, 1'b0, 4'hF, 32'd0, 32'hDEADBEEF, 1'b1, 1'b0);

        // LSU store: acknowledged with rdata forced to 0
        lsu_req_ip   = 1'b1;
        lsu_addr_ip  = 32'h200;
        lsu_we_ip    = 1'b1;
        lsu_be_ip    = 4'b0011;
        lsu_wdata_ip = 32'h1234ABCD;
        run_txn("store", 1'b1, 32'h200, 1'b1, 4'b0011, 32'h1234ABCD, 32'hFFFFFFFF, 1'b1, 1'b0);
        lsu_we_ip    = 1'b0;
        lsu_be_ip    = 4'hF;
        lsu_wdata_ip = 32'd0;

        // Simultaneous requests: LSU first, then the still-pending IF as a full-word read
        if_req_ip   = 1'b1;
        if_addr_ip  = 32'h400;
        lsu_req_ip  = 1'b1;
        lsu_addr_ip = 32'h300;
        lsu_wdata_ip = 32'h55;
        run_txn("simul lsu", 1'b1, 32'h300, 1'b0, 4'hF, 32'h55, 32'h11111111, 1'b1, 1'b0);
        run_txn("simul if", 1'b0, 32'h400, 1'b0, 4'hF, 32'd0, 32'hCAFE0001, 1'b0, 1'b0);

        // Starvation: IF held, LSU continuous -> 4 LSU, 1 IF, then LSU again
        lsu_req_ip  = 1'b1;
        lsu_addr_ip = 32'h500;
        lsu_wdata_ip = 32'd0;
        for (int i = 0; i < 4; i++) begin
            run_txn("starve lsu", 1'b1, 32'h500, 1'b0, 4'hF, 32'd0, 32'hA0 + i, 1'b0, 1'b0);
        end
        run_txn("starve if", 1'b0, 32'h400, 1'b0, 4'hF, 32'd0, 32'hCAFE0002, 1'b0, 1'b0);
        run_txn("starve lsu after", 1'b1, 32'h500, 1'b0, 4'hF, 32'd0, 32'hB0, 1'b1, 1'b1);

        // Delayed gnt with stray rvalid in REQ, including rvalid in the gnt cycle
        lsu_req_ip  = 1'b1;
        lsu_addr_ip = 32'h600;
        tick();
        for (int i = 0; i < 3; i++) begin
            mem_rvalid_ip = 1'b1;
            mem_rdata_ip  = 32'hBAD0 + i;
            #1;
            chk("delay req held", {31'd0, mem_req_op}, 32'd1);
            chk("delay addr stable", mem_addr_op, 32'h600);
            chk("delay no gnt/rvalid", {30'd0, lsu_gnt_op, lsu_rvalid_op}, 32'd0);
            tick();
        end
        mem_gnt_ip = 1'b1;
        #1;
        chk("delay gnt", {31'd0, lsu_gnt_op}, 32'd1);
        chk("delay rvalid with gnt", {31'd0, lsu_rvalid_op}, 32'd0);
        tick();
        mem_gnt_ip    = 1'b0;
        mem_rvalid_ip = 1'b0;
        lsu_req_ip    = 1'b0;
        #1;
        chk("delay wait busy", {31'd0, busy_op}, 32'd1);
        chk("delay wait no rvalid", {31'd0, lsu_rvalid_op}, 32'd0);
        tick();
        mem_rvalid_ip = 1'b1;
        mem_rdata_ip  = 32'h5555AAAA;
        #1;
        chk("delay rvalid", {31'd0, lsu_rvalid_op}, 32'd1);
        chk("delay rdata", lsu_rdata_op, 32'h5555AAAA);
        tick();
        mem_rvalid_ip = 1'b0;
        #1;
        chk("delay idle", {31'd0, busy_op}, 32'd0);

        // Reset while waiting for an IF response; the late rvalid must be dropped
        if_req_ip  = 1'b1;
        if_addr_ip = 32'h700;
        tick();
        mem_gnt_ip = 1'b1;
        #1;
        chk("rstmid gnt", {31'd0, if_gnt_op}, 32'd1);
        tick();
        mem_gnt_ip = 1'b0;
        if_req_ip  = 1'b0;
        reset      = 1'b1;
        #1;
        chk("rstmid during busy", {31'd0, busy_op}, 32'd0);
        chk("rstmid during addr", mem_addr_op, 32'd0);
        tick();
        reset         = 1'b0;
        mem_rvalid_ip = 1'b1;
        mem_rdata_ip  = 32'h77;
        #1;
        chk("rstmid no rvalid", {30'd0, if_rvalid_op, lsu_rvalid_op}, 32'd0);
        chk("rstmid rdata", if_rdata_op, 32'd0);
        chk("rstmid busy", {31'd0, busy_op}, 32'd0);
        chk("rstmid mem", {31'd0, mem_req_op}, 32'd0);
        chk("rstmid addr", mem_addr_op, 32'd0);
        tick();
        mem_rvalid_ip = 1'b0;
        #1;
        chk("rstmid stays idle", {31'd0, busy_op}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single core memory port between two requesters: instruction fetch (IF) and the load/store unit (LSU).
- Arbitrates between them, registers the winner's request onto the memory port and tracks the one outstanding transaction.
- Routes the response (rvalid/rdata) back to the owner only.
- Sits between Fetch/LSU and the memory model, replacing their direct memory connections.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports.
- STARVE_LIMIT, 4, consecutive LSU wins allowed while IF is pending before IF is forced to win.

Ports:
- clock  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- if_req_ip  in  1  fetch request; held with address stable until if_gnt_op.
- if_addr_ip  in  ADDR_WIDTH  fetch address.
- if_gnt_op  out  1  fetch request accepted by memory.
- if_rvalid_op  out  1  fetch response valid (1-cycle pulse).
- if_rdata_op  out  DATA_WIDTH  fetch response data.
- lsu_req_ip  in  1  LSU request; held with fields stable until lsu_gnt_op.
- lsu_we_ip  in  1  1 = store, 0 = load.
- lsu_be_ip  in  DATA_WIDTH/8  byte enables.
- lsu_addr_ip  in  ADDR_WIDTH  LSU address.
- lsu_wdata_ip  in  DATA_WIDTH  store data.
- lsu_gnt_op  out  1  LSU request accepted.
- lsu_rvalid_op  out  1  LSU response valid (1-cycle pulse; also acknowledges stores).
- lsu_rdata_op  out  DATA_WIDTH  load data.
- mem_req_op  out  1  memory request.
- mem_we_op  out  1  memory write enable.
- mem_be_op  out  DATA_WIDTH/8  memory byte enables.
- mem_addr_op  out  ADDR_WIDTH  memory address.
- mem_wdata_op  out  DATA_WIDTH  memory write data.
- mem_gnt_ip  in  1  memory accepts the request.
- mem_rvalid_ip  in  1  memory response valid; also asserted for writes; earliest one cycle after gnt.
- mem_rdata_ip  in  DATA_WIDTH  memory read data.
- busy_op  out  1  a transaction is in flight (state != IDLE).

Behaviour:
- **Reset:** synchronous, active-high. Forces state IDLE, owner NONE, starve counter 0. All outputs read 0 while reset is high and in the first cycle after it.
- **FSM states:** IDLE, REQ, WAIT_RSP.
- **IDLE:**
  - If either request is high, select a winner and register the owner and memory fields (addr, we, be, wdata) into the mem_* registers. Next state REQ.
  - IF requests are registered as we=0, be=all-ones, wdata=0.
  - If no request is high, stay in IDLE.
- **REQ:**
  - mem_req_op = 1; mem_* fields held stable.
  - When mem_gnt_ip = 1: assert the owner's gnt for exactly that cycle, drop mem_req_op (registered low next cycle), next state WAIT_RSP.
- **WAIT_RSP:**
  - When mem_rvalid_ip = 1: pass mem_rvalid_ip to the owner's rvalid in the same cycle (combinational). Owner rdata = mem_rdata_ip, or 0 for a store. Next state IDLE, owner NONE.
  - The non-owner's rvalid and rdata are always 0.
- **Priority and starvation:**
  - LSU wins by default.
  - The counter increments on each LSU win while if_req_ip = 1, saturating at STARVE_LIMIT.
  - When the counter equals STARVE_LIMIT and if_req_ip = 1, IF wins and the counter clears.
  - The counter clears in any IDLE cycle with if_req_ip = 0.
- **Latency:** a minimum of 3 cycles per transaction (IDLE, REQ with immediate gnt, WAIT_RSP with rvalid the cycle after gnt). A new arbitration can occur in the cycle after rvalid.
- **Ignored inputs:**
  - mem_gnt_ip outside REQ.
  - mem_rvalid_ip outside WAIT_RSP, including rvalid in the same cycle as gnt and stale rvalid after reset.
  - Requests arriving during REQ or WAIT_RSP are not granted; they wait for IDLE. Requesters keep req high.
- **Reset mid-transaction:** the in-flight transaction is abandoned and no gnt or rvalid is forwarded for it.

Decomposition:
- CORE_PKG additions:
  - arb_state_e {ARB_IDLE, ARB_REQ, ARB_WAIT_RSP}.
  - arb_owner_e {OWNER_NONE, OWNER_IF, OWNER_LSU}.
- One natural sub-module, mem_arb_select: priority selection plus the starvation counter. Inputs: req vector, clock, reset, arb_en. Outputs: winner (arb_owner_e).
- The FSM, field registers and response routing stay in the top module.

Test Plan:
- **LSU load alone.** lsu_req=1, addr=0x100, we=0. Memory gives gnt in REQ and rvalid=1 with rdata=0xDEADBEEF the next cycle. Expect: mem_addr_op=0x100, lsu_gnt_op pulses once, lsu_rvalid_op=1 with lsu_rdata_op=0xDEADBEEF, if_rvalid_op stays 0, busy_op low after.
- **LSU store.** we=1, be=4'b0011, wdata=0x1234ABCD, addr=0x200. Expect: mem_we_op=1, mem_be_op=0011, mem_wdata_op=0x1234ABCD; on ack, lsu_rvalid_op=1 and lsu_rdata_op=0.
- **Simultaneous requests.** IF and LSU both request in the same IDLE cycle. Expect: LSU is served first. IF, still pending, is served next, with mem_addr_op=IF address, mem_we_op=0, mem_be_op=1111.
- **Starvation.** IF held high while LSU requests continuously; STARVE_LIMIT=4. Expect: 4 LSU transactions, then 1 IF transaction, then LSU again.
- **Delayed gnt and stray inputs.** gnt delayed 3 cycles; inject mem_rvalid_ip during REQ. Expect: mem_req_op held with fields stable, no rvalid forwarded early, and the correct response after the real rvalid.
- **Reset in WAIT_RSP.** Pulse reset for 1 cycle, then deliver mem_rvalid_ip. Expect: state IDLE, no if/lsu rvalid forwarded, all outputs 0.
